// File: rtl/jt51_pkg.sv
// rtl/jt51_pkg.sv - shared timer register map and control-bit positions
package jt51_pkg;

  localparam logic [7:0] REG_CLKA1 = 8'h10;
  localparam logic [7:0] REG_CLKA2 = 8'h11;
  localparam logic [7:0] REG_CLKB  = 8'h12;
  localparam logic [7:0] REG_TCTRL = 8'h14;

  // Bit positions inside the 0x14 timer control byte
  localparam int CSM     = 7;
  localparam int FRST_B  = 5;
  localparam int FRST_A  = 4;
  localparam int IRQEN_B = 3;
  localparam int IRQEN_A = 2;
  localparam int LOAD_B  = 1;
  localparam int LOAD_A  = 0;

  localparam int BUSY_CNT_W = 8;

endpackage

// File: rtl/jt51_busy_cnt.sv
// rtl/jt51_busy_cnt.sv - busy flag held for a fixed number of cen pulses after a load
module jt51_busy_cnt
  import jt51_pkg::*;
#(
  parameter int BUSY_TICKS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic load,
  output logic busy
);

  localparam logic [BUSY_CNT_W-1:0] TICKS = BUSY_CNT_W'(BUSY_TICKS);

  logic [BUSY_CNT_W-1:0] cnt;

  // A load wins over the countdown, so the first decrement is on the next cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= TICKS;
      busy <= 1'b1;
    end else if (cen && busy) begin
      if (cnt == BUSY_CNT_W'(1)) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt - BUSY_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jt51_timer_ctrl.sv
// rtl/jt51_timer_ctrl.sv - CPU port decode, timer registers, busy status and CSM key-on
module jt51_timer_ctrl
  import jt51_pkg::*;
#(
  parameter int BUSY_TICKS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [7:0] dout,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       csm,
  output logic       csm_kon,
  output logic       fwd_wr,
  output logic [7:0] fwd_addr,
  output logic [7:0] fwd_din,
  output logic       busy
);

  logic       we;
  logic       we_l;
  logic       acc;
  logic       data_acc;
  logic       ovA_l;
  logic [7:0] addr_r;

  // One access per falling strobe, however long the CPU holds it
  assign we       = !cs_n && !wr_n;
  assign acc      = we && !we_l;
  assign data_acc = acc && a0 && !busy;

  assign dout = {busy, 5'b0, flag_B, flag_A};

  jt51_busy_cnt #(
    .BUSY_TICKS(BUSY_TICKS)
  ) u_busy_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (cen),
    .load (data_acc),
    .busy (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_l         <= 1'b0;
      ovA_l        <= 1'b0;
      addr_r       <= '0;
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      csm          <= 1'b0;
      csm_kon      <= 1'b0;
      fwd_wr       <= 1'b0;
      fwd_addr     <= '0;
      fwd_din      <= '0;
    end else begin
      we_l       <= we;
      ovA_l      <= overflow_A;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      fwd_wr     <= 1'b0;
      // csm here is still the pre-write value when a 0x14 write lands on the same edge
      csm_kon    <= overflow_A && !ovA_l && csm;

      if (acc && !a0) addr_r <= din;

      if (data_acc) begin
        case (addr_r)
          REG_CLKA1: value_A[9:2] <= din;
          REG_CLKA2: value_A[1:0] <= din[1:0];
          REG_CLKB:  value_B      <= din;
          REG_TCTRL: begin
            csm          <= din[CSM];
            clr_flag_B   <= din[FRST_B];
            clr_flag_A   <= din[FRST_A];
            enable_irq_B <= din[IRQEN_B];
            enable_irq_A <= din[IRQEN_A];
            load_B       <= din[LOAD_B];
            load_A       <= din[LOAD_A];
          end
          default: begin
            fwd_wr   <= 1'b1;
            fwd_addr <= addr_r;
            fwd_din  <= din;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// tb/tb_jt51_timer_ctrl.sv - directed bench for jt51_timer_ctrl
module tb_jt51_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b1;
  logic       overflow_A = 1'b0;
  logic [7:0] dout;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B, csm, csm_kon;
  logic       fwd_wr;
  logic [7:0] fwd_addr, fwd_din;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int         n_clr_a = 0, n_clr_b = 0, n_kon = 0, n_fwd = 0, n_busy_cen = 0;
  logic [7:0] last_fwd_addr = 8'h00, last_fwd_din = 8'h00;

  jt51_timer_ctrl #(.BUSY_TICKS(32)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A), .dout(dout),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .csm(csm), .csm_kon(csm_kon), .fwd_wr(fwd_wr), .fwd_addr(fwd_addr),
    .fwd_din(fwd_din), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cen <= ~cen;

  // Pulse and cen-while-busy tallies; tests compare deltas
  always @(negedge clk) begin
    if (clr_flag_A) n_clr_a++;
    if (clr_flag_B) n_clr_b++;
    if (csm_kon) n_kon++;
    if (fwd_wr) begin
      n_fwd++;
      last_fwd_addr = fwd_addr;
      last_fwd_din  = fwd_din;
    end
    if (busy && cen && rst_n) n_busy_cen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic port, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = port; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse_ovf();
    @(negedge clk);
    overflow_A = 1'b1;
    repeat (3) @(negedge clk);
    overflow_A = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int base_busy, base_a, base_b, base_kon, base_fwd;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'h02);
    chk("rst_value_A", 32'(value_A), 32'd0);
    chk("rst_ctrl", {load_A, load_B, csm, enable_irq_A, enable_irq_B, fwd_wr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Timer A value over two registers, with busy timing
    cpu_wr(1'b0, 8'h10);
    cpu_wr(1'b1, 8'hAB);
    chk("busy_after_wr", 32'(busy), 32'd1);
    wait_idle();
    cpu_wr(1'b0, 8'h11);
    base_busy = n_busy_cen;
    cpu_wr(1'b1, 8'hFF);
    chk("dout_busy", 32'(dout), 32'h82);
    chk("value_A", 32'(value_A), 32'h2AF);

    // Data write while busy is dropped and does not restart the count
    cpu_wr(1'b0, 8'h12);
    cpu_wr(1'b1, 8'h5A);
    chk("value_B_busy", 32'(value_B), 32'h00);
    wait_idle();
    chk("busy_cen_count", 32'(n_busy_cen - base_busy), 32'd32);
    chk("dout_idle", 32'(dout), 32'h02);
    cpu_wr(1'b1, 8'h5A);
    chk("value_B", 32'(value_B), 32'h5A);
    wait_idle();

    // Control write with both flag clears
    base_a = n_clr_a; base_b = n_clr_b;
    cpu_wr(1'b0, 8'h14);
    cpu_wr(1'b1, 8'h3F);
    repeat (3) @(negedge clk);
    chk("clr_A_pulses", 32'(n_clr_a - base_a), 32'd1);
    chk("clr_B_pulses", 32'(n_clr_b - base_b), 32'd1);
    chk("ctrl_3F", {csm, enable_irq_B, enable_irq_A, load_B, load_A}, 32'b01111);
    chk("value_A_kept", 32'(value_A), 32'h2AF);
    wait_idle();

    // CSM on: one key-on per overflow edge
    base_a = n_clr_a;
    cpu_wr(1'b1, 8'h81);
    chk("ctrl_81", {csm, enable_irq_B, enable_irq_A, load_B, load_A}, 32'b10001);
    chk("clr_A_none", 32'(n_clr_a - base_a), 32'd0);
    base_kon = n_kon;
    pulse_ovf();
    chk("csm_kon_one", 32'(n_kon - base_kon), 32'd1);
    wait_idle();
    cpu_wr(1'b1, 8'h01);
    base_kon = n_kon;
    pulse_ovf();
    chk("csm_kon_none", 32'(n_kon - base_kon), 32'd0);
    chk("value_B_kept", 32'(value_B), 32'h5A);
    wait_idle();

    // Non-timer write is forwarded
    base_fwd = n_fwd;
    cpu_wr(1'b0, 8'h28);
    cpu_wr(1'b1, 8'h4C);
    repeat (2) @(negedge clk);
    chk("fwd_count", 32'(n_fwd - base_fwd), 32'd1);
    chk("fwd_addr", 32'(last_fwd_addr), 32'h28);
    chk("fwd_din", 32'(last_fwd_din), 32'h4C);
    chk("timers_unchanged", {value_A, value_B, load_A, load_B}, {10'h2AF, 8'h5A, 2'b10});
    wait_idle();

    // Long address strobe: din changes mid-strobe must not be captured
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; din = 8'h30;
    repeat (2) @(negedge clk);
    din = 8'h12;
    repeat (2) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    // Long data strobe: exactly one access
    base_fwd = n_fwd;
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h99;
    repeat (10) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    chk("hold_fwd_count", 32'(n_fwd - base_fwd), 32'd1);
    chk("hold_fwd_addr", 32'(last_fwd_addr), 32'h30);
    chk("hold_value_B", 32'(value_B), 32'h5A);
    chk("busy_before_rst", 32'(busy), 32'd1);

    // Asynchronous reset mid-busy
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dout", 32'(dout), 32'h02);
    chk("arst_values", {value_A, value_B}, 32'd0);
    chk("arst_ctrl", {load_A, load_B, enable_irq_A, enable_irq_B, csm, csm_kon, fwd_wr}, 32'd0);
    chk("arst_fwd_addr", 32'(fwd_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
